// File: rtl/task1.sv
// task1: fills a 256x8 memory with s[j] = j once after reset, then reports
// completion on LEDR[0]. A small controller starts an init engine with a
// one-cycle en pulse and waits for the engine's rdy handshake to return.

// Init engine: on en it sweeps i = 0..255, writing wrdata = i to addr = i.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request (rdy=1, wren=0); en starts a fill
// FILL  | one write per cycle at addr=i; leaves after writing i=255
module task1_init (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] addr,
  output logic [7:0] wrdata,
  output logic       wren
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t     state, state_nxt;
  logic [7:0] i, i_nxt;

  // State and sweep counter registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= 8'd0;
    end else begin
      state <= state_nxt;
      i     <= i_nxt;
    end
  end

  // Next state, counter advance and handshake outputs.
  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    rdy       = 1'b1;
    wren      = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = FILL;
          i_nxt     = 8'd0;
        end
      end
      FILL: begin
        rdy   = 1'b0;
        wren  = 1'b1;
        // The 8-bit wrap back to 0 after the last write leaves i ready for
        // the next request; no write happens at that point because we are
        // already heading back to IDLE. en is deliberately ignored here.
        i_nxt = i + 8'd1;
        if (i == 8'hFF) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign addr   = i;
  assign wrdata = i;

endmodule

// Top level: board-style ports, sequencing controller and the memory.
//
// state | meaning
// ------+-------------------------------------------------------------
// START | after reset; pulse en for one cycle once the engine is ready
// WAIT  | fill in progress; done when rdy returns after the engine went busy
// DONE  | terminal; LEDR[0] lit
module task1 (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {START, WAIT, DONE} ctrl_t;

  logic       clk_sys;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;
  logic [7:0] s [256];

  ctrl_t      state, state_nxt;
  logic       seen_busy;
  logic       unused_inputs;

  assign clk_sys = CLOCK_50;
  assign rst_n   = KEY[3];

  // Switches and the other keys are intentionally not part of the design.
  assign unused_inputs = ^{SW, KEY[2:0]};

  task1_init u_init (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .en      (en),
    .rdy     (rdy),
    .addr    (addr),
    .wrdata  (wrdata),
    .wren    (wren)
  );

  // Memory write port; contents survive reset on purpose.
  always_ff @(posedge clk_sys) begin
    if (wren) s[addr] <= wrdata;
  end

  // Controller state and the "engine has gone busy" flag.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= START;
      seen_busy <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && !rdy) seen_busy <= 1'b1;
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      START:   if (rdy) state_nxt = WAIT;
      // rdy is only trusted once the engine has been seen busy, so a stale
      // rdy=1 right after the request cannot end the sequence early.
      WAIT:    if (rdy && seen_busy) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = START;
    endcase
  end

  // en is a continuous function of state so it is a single-cycle pulse.
  assign en   = (state == START) && rdy;
  assign LEDR = {9'd0, (state == DONE)};

  assign HEX0 = 7'h7F;
  assign HEX1 = 7'h7F;
  assign HEX2 = 7'h7F;
  assign HEX3 = 7'h7F;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_task1.sv
module tb_task1;

  logic       CLOCK_50;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  int total = 0;
  int bad   = 0;

  int busy, wr, rise;
  bit order_ok, mem_ok;

  task1 dut (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .LEDR     (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic hold_reset();
    tick();
    KEY[3] = 1'b0;
    repeat (5) tick();
  endtask

  // Runs 400 cycles after reset release; measures busy cycles, writes,
  // address order and the sample index at which rdy returns.
  task automatic run_fill(input bit noisy, input int force_on, input int force_off,
                          output int busy_o, output int wr_o, output int rise_o,
                          output bit order_o);
    int exp_addr;
    busy_o = 0; wr_o = 0; rise_o = 0; order_o = 1'b1; exp_addr = 0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      if (noisy) begin
        SW       = 10'($urandom);
        KEY[2:0] = 3'($urandom);
      end
      if (c == force_on)  force dut.en = 1'b1;
      if (c == force_off) release dut.en;
      if (dut.rdy !== 1'b1) busy_o++;
      if (dut.wren === 1'b1) begin
        if (exp_addr > 255 || dut.addr !== exp_addr[7:0]) order_o = 1'b0;
        exp_addr++;
        wr_o++;
      end
      if (dut.rdy === 1'b1 && busy_o > 0 && rise_o == 0) rise_o = c;
    end
    if (exp_addr != 256) order_o = 1'b0;
  endtask

  task automatic scan_mem(output bit ok);
    ok = 1'b1;
    for (int j = 0; j < 256; j++)
      if (dut.s[j] !== 8'(j)) ok = 1'b0;
  endtask

  initial begin
    KEY = 4'b1111;
    SW  = 10'd0;

    // Reset state.
    hold_reset();
    total++; assert (dut.rdy === 1'b1) else begin bad++; $error("FAIL rst_rdy got=%b want=1", dut.rdy); end
    total++; assert (LEDR === 10'h000) else begin bad++; $error("FAIL rst_ledr got=%h want=000", LEDR); end
    total++; assert (dut.wren === 1'b0) else begin bad++; $error("FAIL rst_wren got=%b want=0", dut.wren); end
    total++; assert (HEX0 === 7'h7F) else begin bad++; $error("FAIL hex0 got=%h want=7f", HEX0); end
    total++; assert (HEX1 === 7'h7F) else begin bad++; $error("FAIL hex1 got=%h want=7f", HEX1); end
    total++; assert (HEX2 === 7'h7F) else begin bad++; $error("FAIL hex2 got=%h want=7f", HEX2); end
    total++; assert (HEX3 === 7'h7F) else begin bad++; $error("FAIL hex3 got=%h want=7f", HEX3); end
    total++; assert (HEX4 === 7'h7F) else begin bad++; $error("FAIL hex4 got=%h want=7f", HEX4); end
    total++; assert (HEX5 === 7'h7F) else begin bad++; $error("FAIL hex5 got=%h want=7f", HEX5); end

    // Undisturbed run: en taken at edge 1, busy 256 cycles, rdy back after edge 257.
    KEY[3] = 1'b1;
    run_fill(1'b0, 0, 0, busy, wr, rise, order_ok);
    total++; assert (busy === 256) else begin bad++; $error("FAIL base_busy got=%0d want=256", busy); end
    total++; assert (wr === 256) else begin bad++; $error("FAIL base_wren got=%0d want=256", wr); end
    total++; assert (order_ok === 1'b1) else begin bad++; $error("FAIL base_order got=%b want=1", order_ok); end
    total++; assert (rise === 257) else begin bad++; $error("FAIL base_rise got=%0d want=257", rise); end
    total++; assert (dut.rdy === 1'b1) else begin bad++; $error("FAIL base_rdy got=%b want=1", dut.rdy); end
    total++; assert (LEDR === 10'h001) else begin bad++; $error("FAIL base_ledr got=%h want=001", LEDR); end
    total++; assert (dut.s[0] === 8'd0) else begin bad++; $error("FAIL s0 got=%0d want=0", dut.s[0]); end
    total++; assert (dut.s[1] === 8'd1) else begin bad++; $error("FAIL s1 got=%0d want=1", dut.s[1]); end
    total++; assert (dut.s[128] === 8'd128) else begin bad++; $error("FAIL s128 got=%0d want=128", dut.s[128]); end
    total++; assert (dut.s[255] === 8'd255) else begin bad++; $error("FAIL s255 got=%0d want=255", dut.s[255]); end
    scan_mem(mem_ok);
    total++; assert (mem_ok === 1'b1) else begin bad++; $error("FAIL base_mem got=%b want=1", mem_ok); end

    // Reset pulse after 100 fill cycles.
    hold_reset();
    KEY[3] = 1'b1;
    repeat (101) tick();
    total++; assert (dut.rdy === 1'b0) else begin bad++; $error("FAIL mid_busy got=%b want=0", dut.rdy); end
    total++; assert (dut.addr === 8'd100) else begin bad++; $error("FAIL mid_addr got=%0d want=100", dut.addr); end
    KEY[3] = 1'b0;
    #1;
    total++; assert (dut.rdy === 1'b1) else begin bad++; $error("FAIL async_rdy got=%b want=1", dut.rdy); end
    total++; assert (dut.wren === 1'b0) else begin bad++; $error("FAIL async_wren got=%b want=0", dut.wren); end
    total++; assert (dut.addr === 8'd0) else begin bad++; $error("FAIL async_i got=%0d want=0", dut.addr); end
    total++; assert (LEDR === 10'h000) else begin bad++; $error("FAIL async_ledr got=%h want=000", LEDR); end
    repeat (3) tick();
    KEY[3] = 1'b1;
    run_fill(1'b0, 0, 0, busy, wr, rise, order_ok);
    total++; assert (busy === 256) else begin bad++; $error("FAIL abort_busy got=%0d want=256", busy); end
    total++; assert (order_ok === 1'b1) else begin bad++; $error("FAIL abort_order got=%b want=1", order_ok); end
    total++; assert (rise === 257) else begin bad++; $error("FAIL abort_rise got=%0d want=257", rise); end
    scan_mem(mem_ok);
    total++; assert (mem_ok === 1'b1) else begin bad++; $error("FAIL abort_mem got=%b want=1", mem_ok); end

    // Random SW / KEY[2:0] activity must not change anything.
    hold_reset();
    KEY[3] = 1'b1;
    run_fill(1'b1, 0, 0, busy, wr, rise, order_ok);
    total++; assert (busy === 256) else begin bad++; $error("FAIL noise_busy got=%0d want=256", busy); end
    total++; assert (wr === 256) else begin bad++; $error("FAIL noise_wren got=%0d want=256", wr); end
    total++; assert (order_ok === 1'b1) else begin bad++; $error("FAIL noise_order got=%b want=1", order_ok); end
    total++; assert (rise === 257) else begin bad++; $error("FAIL noise_rise got=%0d want=257", rise); end
    total++; assert (LEDR === 10'h001) else begin bad++; $error("FAIL noise_ledr got=%h want=001", LEDR); end
    scan_mem(mem_ok);
    total++; assert (mem_ok === 1'b1) else begin bad++; $error("FAIL noise_mem got=%b want=1", mem_ok); end
    SW = 10'd0;
    KEY[2:0] = 3'b111;

    // en held high mid-fill must not restart the sweep.
    hold_reset();
    KEY[3] = 1'b1;
    run_fill(1'b0, 50, 200, busy, wr, rise, order_ok);
    total++; assert (rise === 257) else begin bad++; $error("FAIL force_rise got=%0d want=257", rise); end
    total++; assert (busy === 256) else begin bad++; $error("FAIL force_busy got=%0d want=256", busy); end
    total++; assert (order_ok === 1'b1) else begin bad++; $error("FAIL force_order got=%b want=1", order_ok); end
    total++; assert (LEDR === 10'h001) else begin bad++; $error("FAIL force_ledr got=%h want=001", LEDR); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/task1.md
TASK1 -- requirements
Module: task1

Interface
REQ-001 Parameters: none; memory depth fixed at 256, width 8.
REQ-002 CLOCK_50  input  1  the single system clock; all state updates on its rising edge.
REQ-003 KEY  input  4  KEY[3] is the reset, asynchronous and active-low; KEY[2:0] unused.
REQ-004 SW  input  10  unused; no effect on behaviour.
REQ-005 HEX0..HEX5  output  7 each  seven-segment drivers, active-low segments.
REQ-006 LEDR  output  10  status LEDs; LEDR[0] = init-complete flag, LEDR[9:1] = 0.
REQ-007 Internal signal named rdy (1 bit) SHALL exist at the top level of task1 and be hierarchically visible as task1.rdy.

Function
REQ-008 task1 SHALL contain an init engine with handshake ports en (in), rdy (out), addr[7:0], wrdata[7:0], wren (out), plus a 256x8 memory named s with synchronous write.
REQ-009 Memory write: when wren=1 at a rising edge, s[addr] <= wrdata; no read port is required.
REQ-010 Init engine states: IDLE (rdy=1, wren=0) and FILL (rdy=0).
REQ-011 IDLE -> FILL when en=1 at a rising edge; the counter i is cleared to 0 on that edge.
REQ-012 In FILL, each cycle: wren=1, addr=i, wrdata=i; i increments by 1 per cycle (8-bit).
REQ-013 FILL -> IDLE on the edge that writes i=255; no wrap-around write of address 0 occurs.
REQ-014 Latency: en sampled on edge k; rdy=0 from edge k; writes occur on edges k+1..k+256; rdy=1 again after edge k+256 (total 256 busy cycles).
REQ-015 en asserted while in FILL SHALL be ignored; the fill is not restarted.
REQ-016 Top-level controller states: START, WAIT, DONE.
REQ-017 START: drive en=1 for exactly one cycle when rdy=1, then go to WAIT.
REQ-018 WAIT: en=0; go to DONE when rdy=1 is seen after the engine has entered FILL.
REQ-019 DONE: terminal state; en=0; LEDR[0]=1.
REQ-020 HEX0..HEX5 SHALL be 7'b1111111 (all segments off) at all times.
REQ-021 After completion, s[j] SHALL equal j for every j in 0..255.

Reset
REQ-022 KEY[3]=0 SHALL immediately, asynchronously, place the engine in IDLE with rdy=1, i=0, wren=0.
REQ-023 Reset SHALL place the controller in START with en=0 and LEDR=0.
REQ-024 Reset SHALL NOT clear memory contents.
REQ-025 Reset asserted mid-FILL aborts the fill. After release, the sequence restarts from address 0 and completes normally.
REQ-026 Outputs SHALL be stable and defined (no X) from the first reset onward.

Verification
REQ-027 Hold KEY[3]=0 for 5 cycles, then release -> rdy=1 and LEDR=0 during reset; HEX0..5 = 7'h7F.
REQ-028 Release reset and wait 300 cycles -> rdy===1, LEDR[0]=1, s[0]=0, s[1]=1, s[128]=128, s[255]=255.
REQ-029 Release reset and count cycles with rdy=0 -> exactly 256; wren high exactly 256 cycles, addresses 0..255 in order.
REQ-030 Pulse KEY[3] low after 100 FILL cycles -> rdy returns to 1 asynchronously. After release, a full fresh 256-cycle fill is performed and all s[j]=j.
REQ-031 Toggle SW and KEY[2:0] randomly during the fill -> identical timing and memory contents to the undisturbed run.
REQ-032 Force en=1 during FILL -> no restart; rdy rises at the same cycle as in the undisturbed run.
